iq_acq_sequencer: RTL
=====================

Name: iq_acq_sequencer

Overview:
- Sequences the IQ comb decimator over an NMR echo train (CPMG).
- For each of N echoes it:
  - waits for an echo trigger;
  - waits a programmable delay;
  - holds the decimator input-valid high for a fixed window of input samples;
  - collects the decimated outputs and forwards them to a downstream write port (FIFO).
- Sits between the pulse-programmer triggers, the ADC-rate I/Q path and the capture FIFO feeding the host.

Parameters:
- DATA_WIDTH, 32, decimator output / write data width
- DEC_WIDTH, 16, decimation selector width
- CNT_WIDTH, 16, width of delay, window and echo counters
- DRAIN_CYC, 8, cycles to keep forwarding decimator outputs after the window closes

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches config, begins train
- abort  in  1  one-cycle pulse; terminates train
- cfg_dec_sel  in  DEC_WIDTH  decimation factor selector
- cfg_echo_cnt  in  CNT_WIDTH  number of echoes N
- cfg_delay  in  CNT_WIDTH  cycles from trigger to window open
- cfg_win_len  in  CNT_WIDTH  window length in input cycles
- echo_trig  in  1  echo trigger pulse
- dec_sel  out  DEC_WIDTH  to decimator dec_sel
- dec_in_valid  out  1  to decimator in_valid
- dec_reset  out  1  to decimator RESET
- dec_out_valid  in  1  from decimator out_valid
- dec_dataout  in  DATA_WIDTH  from decimator dataout
- wr_en  out  1  write strobe to FIFO
- wr_data  out  DATA_WIDTH  write data
- wr_full  in  1  FIFO full
- busy  out  1  high from the cycle after start until return to IDLE
- done  out  1  one-cycle pulse when the train completes normally
- overflow  out  1  sticky; a word was dropped because wr_full was high

Behaviour:
- Reset values: all outputs 0 except dec_reset=1. FSM goes to IDLE. Latched config and overflow are cleared.
- FSM states: IDLE, ARM, WAIT_TRIG, DELAY, ACQ, DRAIN.
- IDLE:
  - dec_reset is held 0.
  - On start, latch all cfg_* inputs and go to ARM.
  - If latched cfg_echo_cnt==0, pulse done next cycle and stay IDLE.
  - start while busy is ignored.
- ARM:
  - dec_reset=1 for exactly 2 cycles, then WAIT_TRIG.
  - dec_sel is driven from the latched value from ARM onward and stays constant until IDLE.
- WAIT_TRIG: on echo_trig go to DELAY. If latched delay==0, go directly to ACQ.
- DELAY: count latched delay cycles, then ACQ.
- ACQ:
  - dec_in_valid=1 for exactly cfg_win_len cycles, then DRAIN.
  - If win_len==0, skip ACQ and go to DRAIN.
  - echo_trig during DELAY, ACQ or DRAIN is ignored.
- DRAIN:
  - dec_in_valid=0 for DRAIN_CYC cycles; the echo index then increments.
  - If index==N, pulse done and go to IDLE; else go to WAIT_TRIG.
- Forwarding:
  - In ACQ and DRAIN only: when dec_out_valid, register dec_dataout to wr_data and assert wr_en next cycle (1-cycle latency).
  - If wr_full at that time, wr_en stays 0, the word is dropped and overflow is set (sticky until RESET or next start).
  - dec_out_valid in other states is discarded.
- abort (any non-IDLE state):
  - Next cycle: FSM to IDLE, dec_in_valid=0, no done pulse.
  - A forward already registered still completes.
- Simultaneous start and abort in IDLE: start wins. Simultaneous abort and completion: abort wins, so no done pulse.
- Counters saturate; there is no wrap. Echo index width is CNT_WIDTH.

Optional Feature:
- Macro ACQ_ECHO_HEADER_EN.
- When defined:
  - On entry to ACQ, one header word {16'hECE0, echo_index[15:0]} is written through the same path, subject to the wr_full and overflow rules.
  - The header takes priority for that cycle. A coincident dec_out_valid word is held one cycle in a skid register, never dropped for this reason.
- When undefined: no header, and no skid register is synthesised.

Decomposition:
- Shared package iq_acq_pkg holds:
  - state enum (IDLE..DRAIN);
  - header tag constant 16'hECE0;
  - ARM_CYC=2 constant.
- One natural sub-module: iq_acq_fwd, the forwarding/overflow/skid stage. The FSM and counters stay at top level.

Test Plan:
- N=3, delay=5, win=400, dec_sel=3, DRAIN_CYC=8, trigger every 600 cycles, FIFO never full -> dec_in_valid high exactly 3×400 cycles; each window starts 5 cycles after its trigger; one done pulse; overflow=0.
- start with echo_cnt=0 -> done pulses one cycle later; dec_in_valid and dec_reset never toggle; busy stays 0.
- delay=0, win=0 -> no dec_in_valid; FSM passes WAIT_TRIG→DRAIN per trigger; done after N triggers.
- wr_full held high for 10 cycles during ACQ with dec_out_valid every 3rd cycle -> about 3-4 words dropped, overflow=1 and stays 1; the next start clears it.
- abort at cycle 200 of the second window -> dec_in_valid low the next cycle, FSM IDLE, no done; a new start runs normally.
- With ACQ_ECHO_HEADER_EN, N=2 -> first wr_data of each window is 0xECE00000 then 0xECE00001; a dec_out_valid coincident with the header is written the following cycle.

Source files
------------

// File: rtl/iq_acq_pkg.sv
// Shared types and constants for the IQ acquisition sequencer.
package iq_acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    DELAY,
    ACQ,
    DRAIN
  } state_t;

  localparam logic [15:0] HDR_TAG = 16'hECE0;
  localparam int          ARM_CYC = 2;

  function automatic logic [31:0] make_hdr(input logic [15:0] idx);
    return {HDR_TAG, idx};
  endfunction

endpackage

// File: rtl/iq_acq_sequencer_if.sv
// Decimator control/data and capture-FIFO write port seen by the acquisition sequencer.
interface iq_acq_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEC_WIDTH  = 16
);
  logic [DEC_WIDTH-1:0]  dec_sel;
  logic                  dec_in_valid;
  logic                  dec_reset;
  logic                  dec_out_valid;
  logic [DATA_WIDTH-1:0] dec_dataout;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;

  modport master (
    output dec_sel, dec_in_valid, dec_reset, wr_en, wr_data,
    input  dec_out_valid, dec_dataout, wr_full
  );

  modport slave (
    input  dec_sel, dec_in_valid, dec_reset, wr_en, wr_data,
    output dec_out_valid, dec_dataout, wr_full
  );
endinterface

// File: rtl/iq_acq_fwd.sv
// Forwarding stage: decimator output -> FIFO write with sticky overflow.
// ACQ_ECHO_HEADER_EN adds a header source and a one-word skid register.
module iq_acq_fwd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  fwd_en,
`ifdef ACQ_ECHO_HEADER_EN
  input  logic                  hdr_req,
  input  logic [DATA_WIDTH-1:0] hdr_word,
`endif
  input  logic                  dec_out_valid,
  input  logic [DATA_WIDTH-1:0] dec_dataout,
  input  logic                  wr_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  overflow
);
  logic                  live_p0;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  assign live_p0 = fwd_en & dec_out_valid;

`ifdef ACQ_ECHO_HEADER_EN
  logic                  skid_vld_p1;
  logic [DATA_WIDTH-1:0] skid_data_p1;
  logic                  skid_ld;

  // Header beats skid beats live; a displaced live word parks in the skid.
  always_comb begin
    vld_p0  = live_p0;
    data_p0 = dec_dataout;
    skid_ld = 1'b0;
    if (hdr_req) begin
      vld_p0  = 1'b1;
      data_p0 = hdr_word;
      skid_ld = live_p0;
    end else if (skid_vld_p1) begin
      vld_p0  = 1'b1;
      data_p0 = skid_data_p1;
      skid_ld = live_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      skid_vld_p1 <= 1'b0;
    end else begin
      skid_vld_p1 <= skid_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_ld) begin
      skid_data_p1 <= dec_dataout;
    end
  end
`else
  assign vld_p0  = live_p0;
  assign data_p0 = dec_dataout;
`endif

  // p0 -> p1: one-cycle registered write; a full FIFO drops the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_data  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= vld_p0 & ~wr_full;
      if (vld_p0 && !wr_full) begin
        wr_data <= data_p0;
      end
      if (clr) begin
        overflow <= 1'b0;
      end else if (vld_p0 && wr_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_acq_sequencer.sv
// CPMG echo-train sequencer driving the IQ comb decimator and the capture FIFO.
// Optional per-window header word: define ACQ_ECHO_HEADER_EN.
module iq_acq_sequencer
  import iq_acq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEC_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int DRAIN_CYC  = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DEC_WIDTH-1:0] cfg_dec_sel,
  input  logic [CNT_WIDTH-1:0] cfg_echo_cnt,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_win_len,
  input  logic                 echo_trig,
  iq_acq_sequencer_if.master   io,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);
  localparam logic [CNT_WIDTH-1:0] ARM_LAST   = CNT_WIDTH'(ARM_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYC - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] echo_idx;
  logic [CNT_WIDTH-1:0] idx_inc;
  logic [DEC_WIDTH-1:0] dec_sel_q;
  logic [CNT_WIDTH-1:0] echo_cnt_q;
  logic [CNT_WIDTH-1:0] delay_q;
  logic [CNT_WIDTH-1:0] win_q;
  logic                 start_acc;
  logic                 echo_inc;
  logic                 done_nxt;
  logic                 fwd_en;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign idx_inc = sat_inc(echo_idx);

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    echo_inc  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (cfg_echo_cnt == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ARM;
          end
        end
      end
      ARM: begin
        if (cnt == ARM_LAST) begin
          state_nxt = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (echo_trig) begin
          if (delay_q != '0) begin
            state_nxt = DELAY;
          end else if (win_q != '0) begin
            state_nxt = ACQ;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DELAY: begin
        if (cnt == delay_q - 1'b1) begin
          state_nxt = (win_q != '0) ? ACQ : DRAIN;
        end
      end
      ACQ: begin
        if (cnt == win_q - 1'b1) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          echo_inc = 1'b1;
          if (idx_inc == echo_cnt_q) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_TRIG;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides completion so a killed train never reports done.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      echo_inc  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      echo_idx     <= '0;
      dec_sel_q    <= '0;
      echo_cnt_q   <= '0;
      delay_q      <= '0;
      win_q        <= '0;
      done         <= 1'b0;
      io.dec_reset <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= (state_nxt != state) ? '0 : sat_inc(cnt);
      done         <= done_nxt;
      io.dec_reset <= (state_nxt == ARM);
      if (start_acc) begin
        dec_sel_q  <= cfg_dec_sel;
        echo_cnt_q <= cfg_echo_cnt;
        delay_q    <= cfg_delay;
        win_q      <= cfg_win_len;
        echo_idx   <= '0;
      end else if (echo_inc) begin
        echo_idx <= idx_inc;
      end
    end
  end

  assign busy            = (state != IDLE);
  assign io.dec_in_valid = (state == ACQ);
  assign io.dec_sel      = busy ? dec_sel_q : '0;
  assign fwd_en          = (state == ACQ) || (state == DRAIN);

`ifdef ACQ_ECHO_HEADER_EN
  logic                  hdr_req;
  logic [DATA_WIDTH-1:0] hdr_word;

  // The counter restarts on every state change, so cnt==0 marks ACQ entry.
  assign hdr_req  = (state == ACQ) && (cnt == '0);
  assign hdr_word = DATA_WIDTH'(make_hdr(16'(echo_idx)));
`endif

  iq_acq_fwd #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fwd (
    .clk          (CLK),
    .rst          (RESET),
    .clr          (start_acc),
    .fwd_en       (fwd_en),
`ifdef ACQ_ECHO_HEADER_EN
    .hdr_req      (hdr_req),
    .hdr_word     (hdr_word),
`endif
    .dec_out_valid(io.dec_out_valid),
    .dec_dataout  (io.dec_dataout),
    .wr_full      (io.wr_full),
    .wr_en        (io.wr_en),
    .wr_data      (io.wr_data),
    .overflow     (overflow)
  );

endmodule
